// File: rtl/control_mult_sumador.sv
// control_mult_sumador: multi-cycle shift-and-add unsigned multiplier controller.
// It drives an external N-bit ripple adder (SumadorNbits) through the add_*
// ports. Each clock consumes one partial product. A start pulse accepted in
// IDLE runs N add/shift steps. The 2N-bit product is then presented together
// with a one-cycle done pulse.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start, a, b       request and operands, captured on the accepting edge
//   busy              high during the N RUN cycles
//   done              one-cycle completion pulse
//   product           registered 2N-bit result, held until next completion
//   ovf               (MULT_OVF_EN only) product does not fit in N bits
//   add_a/add_b/add_cin  adder operands (combinational from registers)
//   add_sum/add_cout  adder result, consumed in the same cycle
//
// Optional feature macro: MULT_OVF_EN adds the registered ovf output.
module control_mult_sumador #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
`ifdef MULT_OVF_EN
  output logic           ovf,
`endif
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    m;
  logic [N-1:0]    acc;
  logic [N-1:0]    q;
  logic [CW-1:0]   cnt;

  logic            step_c;
  logic [N-1:0]    step_s;
  logic [N-1:0]    acc_next;
  logic [N-1:0]    q_next;
  logic [2*N-1:0]  product_next;
  logic            last_step;

  // The adder only sees M when the current multiplier bit is set.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a = acc;
      if (q[0]) add_b = m;
    end
  end

  // One shift-and-add step. The carry-out is shifted into the top of ACC.
  always_comb begin
    step_c = 1'b0;
    step_s = acc;
    if (q[0]) begin
      step_c = add_cout;
      step_s = add_sum;
    end
    acc_next     = {step_c, step_s[N-1:1]};
    q_next       = {step_s[0], q[N-1:1]};
    product_next = {acc_next, q_next};
  end

  assign last_step = (cnt == CW'(N - 1));

  // Sequencer with registered status and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MULT_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            product <= product_next;
`ifdef MULT_OVF_EN
            ovf     <= |product_next[2*N-1:N];
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_mult_sumador.sv
// Scoreboard bench for control_mult_sumador. It uses a behavioural adder and
// a reference model based on plain multiplication.
module tb_control_mult_sumador;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
`ifdef MULT_OVF_EN
  logic           ovf;
`endif
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic [N:0]     add_full;

  // Stand-in for SumadorNbits.
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_sum  = add_full[N-1:0];
  assign add_cout = add_full[N];

  control_mult_sumador #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
`ifdef MULT_OVF_EN
    .ovf      (ovf),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [2*N-1:0] exp_q[$];
  int             acc_edge_q[$];
  int             busy_len = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0;
    end else begin
      chk("busy_and_done_exclusive", {63'd0, busy & done}, 64'd0);
      chk("add_cin_zero", {63'd0, add_cin}, 64'd0);
      if (busy) busy_len++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [2*N-1:0] e;
          int             ae;
          e  = exp_q.pop_front();
          ae = acc_edge_q.pop_front();
          chk("product", 64'(product), 64'(e));
          chk("done_latency", 64'(cyc - ae), 64'(N));
          chk("busy_cycles", 64'(busy_len), 64'(N));
`ifdef MULT_OVF_EN
          chk("ovf", {63'd0, ovf}, {63'd0, (e >> N) != 0});
`endif
        end
        busy_len = 0;
      end
    end
  end

  // One operation. The multiplier bits are walked and add_b is checked on each step.
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y,
                       input bit chg, input logic [N-1:0] nx, input logic [N-1:0] ny);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back((2*N)'(x) * (2*N)'(y));
    acc_edge_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    if (chg) begin
      a = nx;
      b = ny;
    end
    for (int i = 0; i < int'(N); i++) begin
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("add_b_step", 64'(add_b), y[i] ? 64'(x) : 64'd0);
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_add_a", 64'(add_a), 64'd0);
    chk("reset_add_b", 64'(add_b), 64'd0);
`ifdef MULT_OVF_EN
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
`endif

    // Directed cases.
    do_op(8'd13, 8'd11, 1'b0, 8'd0, 8'd0);
    do_op(8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
    do_op(8'd0, 8'd200, 1'b0, 8'd0, 8'd0);
    do_op(8'd200, 8'd0, 1'b0, 8'd0, 8'd0);
    do_op(8'd7, 8'd9, 1'b1, 8'hAA, 8'h55);

    // Start held high: completions at N+2 spacing.
    @(negedge clk);
    start = 1'b1;
    a = 8'd3;
    b = 8'd5;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'd15);
      acc_edge_q.push_back(cyc + 1 + k * int'(N + 2));
    end
    repeat (3 * (N + 2)) @(negedge clk);
    start = 1'b0;
    repeat (N + 2) @(negedge clk);

    // Reset during RUN aborts without done.
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    b = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    reset = 1'b0;
    repeat (N + 2) @(negedge clk);
    do_op(8'd2, 8'd2, 1'b0, 8'd0, 8'd0);

    // Randomized operations.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] rx, ry, nx, ny;
      rx = N'($urandom);
      ry = N'($urandom);
      nx = N'($urandom);
      ny = N'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(rx, ry, 1'($urandom), nx, ny);
    end

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
